// File: rtl/sata_rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// sata_rx_frame_buffer
//
// Receive buffer between the SATA link-layer frame decoder and the transport
// layer. Words are stored in a 2^DEPTH_LOG2-entry circular memory addressed
// by three binary pointers that carry an extra wrap bit:
//   wr_ptr : next entry to write (speculative, may be rolled back)
//   cm_ptr : end of the committed region visible to the reader
//   rd_ptr : next entry to read
// fill  = wr_ptr - rd_ptr  (drives full/high, includes uncommitted words)
// level = cm_ptr - rd_ptr  (drives empty/low, committed words only)
//
// Optional feature macro: SATA_RX_FRAME_BUFFER_ROLLBACK_EN
//   defined     : commit publishes written words, discard rolls wr_ptr back
//                 to cm_ptr (discard wins over commit).
//   not defined : cm_ptr follows wr_ptr, commit/discard are ignored.
//
// Handshake: a write is accepted when en_wr=1 and full=0; a read is accepted
// when en_rd=1 and empty=0. Rejected requests have no side effect except
// that a write attempted while full raises drop for one cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en_wr, data_wr write request / data
//   commit,discard frame publish / roll back
//   full, high     fill == depth, fill >= HIGH_MARK
//   drop           registered pulse: write attempted while full
//   en_rd          read request
//   data_rd        registered read data (valid the cycle after the read)
//   empty, low     level == 0, level <= LOW_MARK
//   level          committed words available to the reader
// ---------------------------------------------------------------------------
module sata_rx_frame_buffer #(
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH_LOG2 = 3,
    parameter int HIGH_MARK  = 6,
    parameter int LOW_MARK   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  commit,
    input  logic                  discard,
    output logic                  full,
    output logic                  high,
    output logic                  drop,
    input  logic                  en_rd,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  empty,
    output logic                  low,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] HIGH_P  = PW'(HIGH_MARK);
    localparam logic [PW-1:0] LOW_P   = PW'(LOW_MARK);
    localparam logic [PW-1:0] ONE     = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] fill;
    logic [PW-1:0] level_int;
    logic          write;
    logic          read;
    logic          store;

    // Flags are purely combinational from the pointer registers.
    assign fill      = wr_ptr - rd_ptr;
    assign level_int = cm_ptr - rd_ptr;
    assign full      = (fill == DEPTH_P);
    assign high      = (fill >= HIGH_P);
    assign empty     = (level_int == '0);
    assign low       = (level_int <= LOW_P);
    assign level     = level_int;

    assign write = en_wr & ~full;
    assign read  = en_rd & ~empty;

`ifdef SATA_RX_FRAME_BUFFER_ROLLBACK_EN
    // A write that coincides with discard is neither stored nor counted.
    assign store = write & ~discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
        end else begin
            if (discard) begin
                wr_ptr <= cm_ptr;
            end else begin
                if (write) begin
                    wr_ptr <= wr_ptr + ONE;
                end
                // Commit includes a word written in the same cycle.
                if (commit) begin
                    cm_ptr <= wr_ptr + {{(PW-1){1'b0}}, write};
                end
            end
        end
    end
`else
    logic unused_ctrl;

    assign store       = write;
    assign cm_ptr      = wr_ptr;
    assign unused_ctrl = commit | discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (write) begin
            wr_ptr <= wr_ptr + ONE;
        end
    end
`endif

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            data_rd <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= en_wr & full;
            if (read) begin
                data_rd <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                rd_ptr  <= rd_ptr + ONE;
            end
        end
    end

endmodule

// File: tb/tb_sata_rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_sata_rx_frame_buffer
//
// Directed bench for sata_rx_frame_buffer with default parameters (8 entries,
// HIGH_MARK 6, LOW_MARK 1). A small reference model (pending queue plus a
// committed queue exp_q) tracks which words the reader may see; it follows
// SATA_RX_FRAME_BUFFER_ROLLBACK_EN so the same bench covers both builds.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_sata_rx_frame_buffer;

    localparam int DW    = 37;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          en_wr;
    logic [DW-1:0] data_wr;
    logic          commit;
    logic          discard;
    logic          full;
    logic          high;
    logic          drop;
    logic          en_rd;
    logic [DW-1:0] data_rd;
    logic          empty;
    logic          low;
    logic [3:0]    level;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] exp_data;
    bit            did_rd;

    sata_rx_frame_buffer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_wr   (en_wr),
        .data_wr (data_wr),
        .commit  (commit),
        .discard (discard),
        .full    (full),
        .high    (high),
        .drop    (drop),
        .en_rd   (en_rd),
        .data_rd (data_rd),
        .empty   (empty),
        .low     (low),
        .level   (level)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // Drives one cycle of stimulus and updates the reference model with what
    // the buffer is expected to accept during that edge.
    task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit cm,
                         input bit dc, input bit rd);
        int  lvl_pre;
        int  fill_pre;
        bit  acc;
        en_wr   = wr;
        data_wr = d;
        commit  = cm;
        discard = dc;
        en_rd   = rd;
        lvl_pre  = exp_q.size();
        fill_pre = lvl_pre + pend_q.size();
        did_rd   = rd && (lvl_pre > 0);
        if (did_rd) exp_data = exp_q.pop_front();
        acc = wr && (fill_pre < DEPTH);
`ifdef SATA_RX_FRAME_BUFFER_ROLLBACK_EN
        if (dc) begin
            pend_q.delete();
        end else begin
            if (acc) pend_q.push_back(d);
            if (cm) begin
                foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
                pend_q.delete();
            end
        end
`else
        if (acc) exp_q.push_back(d);
`endif
        @(posedge clk);
        #1;
        en_wr   = 1'b0;
        commit  = 1'b0;
        discard = 1'b0;
        en_rd   = 1'b0;
        data_wr = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        en_wr   = 1'b0;
        en_rd   = 1'b0;
        commit  = 1'b0;
        discard = 1'b0;
        data_wr = '0;
        exp_data = '0;
        #2;
        checks++;
        if (data_rd !== '0 || drop !== 1'b0 || level !== 4'd0 || empty !== 1'b1 ||
            full !== 1'b0 || high !== 1'b0 || low !== 1'b1) begin
            failures++;
            $display("FAIL reset_values act: data_rd=%h drop=%b level=%0d empty=%b full=%b high=%b low=%b exp: 0 0 0 1 0 0 1",
                     data_rd, drop, level, empty, full, high, low);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), (i == 8), 1'b0, 1'b0);
            checks++;
            if (high !== (i >= 6)) begin
                failures++;
                $display("FAIL fill_high word=%0d act=%b exp=%b", i, high, (i >= 6));
            end
            checks++;
            if (level !== 4'(exp_q.size())) begin
                failures++;
                $display("FAIL fill_level word=%0d act=%0d exp=%0d", i, level, exp_q.size());
            end
        end
        checks++;
        if (full !== 1'b1 || high !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL full_flags act: full=%b high=%b level=%0d exp: 1 1 8", full, high, level);
        end
        cycle(1'b1, DW'(9), 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop !== 1'b1 || level !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL drop_pulse act: drop=%b level=%0d full=%b exp: 1 8 1", drop, level, full);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL drop_clear act=%b exp=0", drop);
        end
    endtask

    task automatic test_read_order();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (data_rd !== DW'(i)) begin
                failures++;
                $display("FAIL read_order idx=%0d act=%h exp=%h", i, data_rd, DW'(i));
            end
            checks++;
            if (low !== ((8 - i) <= 1)) begin
                failures++;
                $display("FAIL read_low idx=%0d act=%b exp=%b", i, low, ((8 - i) <= 1));
            end
        end
        checks++;
        if (empty !== 1'b1 || low !== 1'b1 || level !== 4'd0) begin
            failures++;
            $display("FAIL drained act: empty=%b low=%b level=%0d exp: 1 1 0", empty, low, level);
        end
        // Read while empty must leave data_rd untouched.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (data_rd !== DW'(8) || empty !== 1'b1) begin
            failures++;
            $display("FAIL read_empty act: data_rd=%h empty=%b exp: 8 1", data_rd, empty);
        end
    endtask

    task automatic test_discard();
        int n;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, DW'('h50 + k), 1'b0, 1'b0, 1'b0);
            checks++;
            if (level !== 4'(exp_q.size()) || empty !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL discard_pre k=%0d act: level=%0d empty=%b exp: %0d %b",
                         k, level, empty, exp_q.size(), (exp_q.size() == 0));
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (level !== 4'(exp_q.size()) || high !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL discard_post act: level=%0d high=%b full=%b exp: %0d 0 0",
                     level, high, full, exp_q.size());
        end
        cycle(1'b1, DW'('hA0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'('hA1), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'('hA2), 1'b1, 1'b0, 1'b0);
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (data_rd !== exp_data) begin
                failures++;
                $display("FAIL discard_readback idx=%0d act=%h exp=%h", j, data_rd, exp_data);
            end
        end
        checks++;
        if (exp_data !== DW'('hA2) || empty !== 1'b1) begin
            failures++;
            $display("FAIL discard_last act: data_rd=%h empty=%b exp: a2 1", data_rd, empty);
        end
    endtask

    task automatic test_commit_discard();
        int n;
        cycle(1'b1, DW'('h31), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'('h32), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'('h33), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'('h34), 1'b1, 1'b1, 1'b0);
        checks++;
        if (level !== 4'(exp_q.size())) begin
            failures++;
            $display("FAIL commit_vs_discard_level act=%0d exp=%0d", level, exp_q.size());
        end
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (data_rd !== exp_data) begin
                failures++;
                $display("FAIL commit_vs_discard_read idx=%0d act=%h exp=%h", j, data_rd, exp_data);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, DW'('hC0 + i), (i == 7), 1'b0, 1'b0);
            checks++;
            if (drop !== 1'b0) begin
                failures++;
                $display("FAIL refill_drop idx=%0d act=%b exp=0", i, drop);
            end
        end
        checks++;
        if (full !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL refill_full act: full=%b level=%0d exp: 1 8", full, level);
        end
        for (int j = 0; j < 8; j++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (data_rd !== DW'('hC0 + j)) begin
                failures++;
                $display("FAIL refill_read idx=%0d act=%h exp=%h", j, data_rd, DW'('hC0 + j));
            end
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] next_val;
        next_val = DW'('h100);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'('h100 + i), 1'b1, 1'b0, 1'b1);
            checks++;
            if (drop !== 1'b0) begin
                failures++;
                $display("FAIL stream_drop cyc=%0d act=%b exp=0", i, drop);
            end
            if (did_rd) begin
                checks++;
                if (data_rd !== next_val) begin
                    failures++;
                    $display("FAIL stream_data cyc=%0d act=%h exp=%h", i, data_rd, next_val);
                end
                next_val = next_val + 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            if (did_rd) begin
                checks++;
                if (data_rd !== next_val) begin
                    failures++;
                    $display("FAIL stream_tail idx=%0d act=%h exp=%h", j, data_rd, next_val);
                end
                next_val = next_val + 1'b1;
            end
        end
        checks++;
        if (data_rd !== DW'('h113) || empty !== 1'b1) begin
            failures++;
            $display("FAIL stream_end act: data_rd=%h empty=%b exp: 113 1", data_rd, empty);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, DW'('h60 + i), (i == 4), 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (level !== 4'd4 || data_rd !== DW'('h60)) begin
            failures++;
            $display("FAIL pre_reset act: level=%0d data_rd=%h exp: 4 60", level, data_rd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_rd !== '0 || drop !== 1'b0 || level !== 4'd0 || empty !== 1'b1 ||
            full !== 1'b0 || high !== 1'b0 || low !== 1'b1) begin
            failures++;
            $display("FAIL async_reset act: data_rd=%h drop=%b level=%0d empty=%b full=%b high=%b low=%b exp: 0 0 0 1 0 0 1",
                     data_rd, drop, level, empty, full, high, low);
        end
        exp_q.delete();
        pend_q.delete();
        exp_data = '0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, DW'('h77), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (data_rd !== DW'('h77) || empty !== 1'b1) begin
            failures++;
            $display("FAIL post_reset act: data_rd=%h empty=%b exp: 77 1", data_rd, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_read_order();
        test_discard();
        test_commit_discard();
        test_stream();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
